spi_txn_ctrl: RTL

Multi-byte SPI transaction controller placed directly upstream of the byte-level SPI master on the ADC board. It takes one command (chip-select index, byte count, payload, SPI mode) and owns the chip-select lines. It streams the payload to the master one byte at a time, collects the returned bytes and reports a single completion pulse. It enforces CS setup, hold and inactive-gap timing, none of which the master provides.

---
 rtl/spi_txn_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/spi_txn_ctrl.sv
// Multi-byte SPI transaction controller: owns the chip selects, streams a command's payload
// through a byte-level SPI master and enforces CS setup, hold and inactive-gap timing.
module spi_txn_ctrl #(
  parameter  int NUM_CS           = 4,
  parameter  int MAX_BYTES        = 4,
  parameter  int CS_SETUP_CLKS    = 4,
  parameter  int CS_HOLD_CLKS     = 4,
  parameter  int CS_INACTIVE_CLKS = 8,
  localparam int LW = $clog2(MAX_BYTES + 1),
  localparam int SW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Start,
  input  logic [SW-1:0]          i_CS_Sel,
  input  logic [LW-1:0]          i_Len,
  input  logic [1:0]             i_Mode,
  input  logic [8*MAX_BYTES-1:0] i_TX_Data,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Err,
  output logic [8*MAX_BYTES-1:0] o_RX_Data,
  output logic [NUM_CS-1:0]      o_CS_n,
  output logic [7:0]             o_M_TX_Byte,
  output logic                   o_M_TX_DV,
  input  logic                   i_M_TX_Ready,
  input  logic                   i_M_RX_DV,
  input  logic [7:0]             i_M_RX_Byte,
  output logic [1:0]             o_M_Mode
);

  localparam int MAX_SH  = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int MAX_CNT = (MAX_SH > CS_INACTIVE_CLKS) ? MAX_SH : CS_INACTIVE_CLKS;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] SETUP_LOAD = CW'(CS_SETUP_CLKS - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(CS_HOLD_CLKS - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(CS_INACTIVE_CLKS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SEND, WAIT_RX, HOLD, GAP} state_t;

  state_t                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [LW-1:0]            len_q;
  logic [LW-1:0]            idx_q;
  logic [8*MAX_BYTES-1:0]   tx_q;
  logic [8*MAX_BYTES-1:0]   rx_q;
  logic [NUM_CS-1:0]        cs_n_q;
  logic [1:0]               mode_q;
  logic [7:0]               tx_byte_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;

  logic                     cmd_bad;
  logic [LW-1:0]            idx_nxt;

  assign cmd_bad = (i_Len == '0) || (int'(i_Len) > MAX_BYTES) || (int'(i_CS_Sel) >= NUM_CS);
  assign idx_nxt = idx_q + LW'(1);

  // NOTE: every register below is written with <= so all of them update from the same
  // pre-edge values; a blocking = here would let later statements see half-updated state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      cs_n_q    <= '1;
      mode_q    <= '0;
      tx_byte_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_Start) begin
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              len_q   <= i_Len;
              mode_q  <= i_Mode;
              tx_q    <= i_TX_Data;
              rx_q    <= '0;
              idx_q   <= '0;
              cnt_q   <= SETUP_LOAD;
              cs_n_q  <= ~(NUM_CS'(1) << i_CS_Sel);
              busy_q  <= 1'b1;
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            tx_byte_q <= tx_q[8*idx_q +: 8];
            state_q   <= SEND;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        SEND: begin
          if (i_M_TX_Ready) state_q <= WAIT_RX;
        end
        WAIT_RX: begin
          if (i_M_RX_DV) begin
            rx_q[8*idx_q +: 8] <= i_M_RX_Byte;
            idx_q              <= idx_nxt;
            if (idx_nxt == len_q) begin
              cnt_q   <= HOLD_LOAD;
              state_q <= HOLD;
            end else begin
              tx_byte_q <= tx_q[8*idx_nxt +: 8];
              state_q   <= SEND;
            end
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            cs_n_q  <= '1;
            done_q  <= 1'b1;
            cnt_q   <= GAP_LOAD;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The byte strobe is gated by the master's ready in the same cycle, so it can never
  // fire into a busy master and goes out on the very cycle ready returns.
  assign o_M_TX_DV   = (state_q == SEND) && i_M_TX_Ready;
  assign o_M_TX_Byte = tx_byte_q;
  assign o_M_Mode    = mode_q;
  assign o_CS_n      = cs_n_q;
  assign o_RX_Data   = rx_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Err       = err_q;

endmodule
